e203_ifu_bpu_rfrd_arb: RTL
==========================

Name: e203_ifu_bpu_rfrd_arb

Overview:
Controller and arbiter for the single regfile rs1 read port shared by two requesters:
- the IFU lite branch predictor, which reads xN (N≠0,1) to form a JALR target;
- the debug module's abstract-command GPR reads.

The block sequences the BPU read around its dependency-wait window and prevents debug starvation. It sits in the IFU between the mini-decoder/BPU and the regfile read port.

Parameters:
RFIDX_W, 5, regfile index width
XLEN, 32, data width
STARVE_MAX, 4, pending debug cycles before debug gets forced priority
CNT_W, 3, starvation counter width (must hold STARVE_MAX)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
bpu_req  in  1  decoded valid JALR with rs1=xN, held until response or flush
bpu_req_idx  in  RFIDX_W  JALR rs1 index
bpu_dep  in  1  xN has a hazard (OITF non-empty, or IR busy and not clearing)
bpu_flush  in  1  IFU flush; cancels BPU activity
bpu_wait  out  1  stall the IFU next-PC
bpu_rsp_vld  out  1  one-cycle pulse; bpu_rsp_data is valid
bpu_rsp_data  out  XLEN  rs1 value for the target adder
dbg_req_vld  in  1  debug read request
dbg_req_rdy  out  1  debug request accepted
dbg_req_idx  in  RFIDX_W  debug GPR index
dbg_rsp_vld  out  1  debug response valid
dbg_rsp_rdy  in  1  debug response accepted
dbg_rsp_data  out  XLEN  registered debug read data
rf_rd_ena  out  1  regfile read strobe
rf_rd_idx  out  RFIDX_W  regfile read index
rf_rd_data  in  XLEN  read data, valid the cycle after rf_rd_ena

Behaviour:
- FSM states: IDLE, DEP_WAIT, BPU_RD, DBG_RD, DBG_RSP. All are encoded in a dfflr-style register with async reset on rst.
- Reset values:
  - state=IDLE, starve_cnt=0, dbg_rsp_data=0;
  - all outputs 0 (bpu_wait follows bpu_req combinationally, so it is 0 while bpu_req=0).
- Grant evaluation happens in IDLE and DEP_WAIT:
  - bpu_ok = bpu_req & ~bpu_dep & ~bpu_flush.
  - dbg_win = dbg_req_vld & (~bpu_ok | starve_cnt==STARVE_MAX).
  - bpu_win = bpu_ok & ~dbg_win.
- Grant cycle actions:
  - bpu_win: rf_rd_ena=1, rf_rd_idx=bpu_req_idx, next state BPU_RD.
  - dbg_win: rf_rd_ena=1, rf_rd_idx=dbg_req_idx, dbg_req_rdy=1, next state DBG_RD.
  - Otherwise: if bpu_req & ~bpu_flush, go to DEP_WAIT; else go to IDLE.
- dbg_req_rdy is asserted only in a dbg_win cycle.
- BPU_RD:
  - bpu_rsp_vld = ~bpu_flush; bpu_rsp_data = rf_rd_data (combinational pass-through, 1-cycle read latency).
  - Next state IDLE.
- DBG_RD: capture rf_rd_data into dbg_rsp_data; next state DBG_RSP.
- DBG_RSP: dbg_rsp_vld=1 until dbg_rsp_rdy, then IDLE. No new grant is issued while in DBG_RSP.
- bpu_wait = bpu_req & ~(state==BPU_RD & ~bpu_flush). The IFU is stalled from the request cycle through the grant cycle; wait drops in the response cycle.
- starve_cnt:
  - increments while dbg_req_vld & ~dbg_req_rdy, saturating at STARVE_MAX;
  - clears on dbg grant;
  - holds when dbg_req_vld=0.
- Flush:
  - In DEP_WAIT, go to IDLE.
  - In BPU_RD, suppress bpu_rsp_vld and return to IDLE.
  - A read already issued is harmless.
  - Debug states are unaffected by flush.
- bpu_req deasserting without flush is treated as a flush.
- Simultaneous arrival: BPU wins unless the starvation counter is saturated. A BPU request arriving while a debug transaction is in flight waits in bpu_wait until the FSM returns to IDLE.
- Async reset mid-transaction drops all state immediately. No response is produced for an in-flight request.

Decomposition:
- Shared package/defines: FSM state encodings (3-bit localparams) and STARVE_MAX default, alongside the existing E203 RFIDX/XLEN widths.
- One natural sub-module: e203_ifu_rfrd_starve_cnt, the saturating counter with clear and increment, reusable by other arbiters.
- The FSM, grant logic and dbg_rsp_data register stay in the top module.

Test Plan:
1. BPU idx=5, bpu_dep=0, no debug request:
   - rf_rd_ena=1 with idx=5 in cycle 0;
   - bpu_rsp_vld=1 with data=rf[5]=0x8000_0100 in cycle 1;
   - bpu_wait=1 in cycle 0 only.
2. BPU with bpu_dep=1 for 3 cycles, then 0: FSM in DEP_WAIT with bpu_wait=1 for 3 cycles, grant in cycle 3, response in cycle 4.
3. Debug idx=10, rf[10]=0xDEAD_BEEF, dbg_rsp_rdy low for 2 cycles: dbg_rsp_vld is held with data 0xDEAD_BEEF until rdy, then the FSM returns to IDLE.
4. BPU and debug continuously requesting, STARVE_MAX=4:
   - BPU served while starve_cnt counts 1..4;
   - next grant goes to debug and starve_cnt returns to 0.
5. Flush asserted during BPU_RD: bpu_rsp_vld stays 0, state becomes IDLE; a following BPU request is served normally.
6. rst asserted during DBG_RSP: dbg_rsp_vld drops immediately, and state, counter and data all read 0 after release.

Source files
------------

// File: rtl/e203_ifu_bpu_rfrd_arb_pkg.sv
// Shared widths, FSM encodings and arbitration defaults for the IFU
// rs1 read-port arbiter.
package e203_ifu_bpu_rfrd_arb_pkg;

   localparam int E203_RFIDX_W = 5;
   localparam int E203_XLEN    = 32;
   localparam int STARVE_MAX_D = 4;
   localparam int CNT_W_D      = 3;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DEP_WAIT = 3'd1;
   localparam logic [2:0] ST_BPU_RD   = 3'd2;
   localparam logic [2:0] ST_DBG_RD   = 3'd3;
   localparam logic [2:0] ST_DBG_RSP  = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      DEP_WAIT = ST_DEP_WAIT,
      BPU_RD   = ST_BPU_RD,
      DBG_RD   = ST_DBG_RD,
      DBG_RSP  = ST_DBG_RSP
   } rfrd_state_e;

endpackage

// File: rtl/e203_ifu_bpu_rfrd_arb_if.sv
// BPU, debug and regfile-port signals of the rs1 read arbiter.
// slave = the arbiter itself, master = requesters plus the regfile.
interface e203_ifu_bpu_rfrd_arb_if
   import e203_ifu_bpu_rfrd_arb_pkg::*;
#(
   parameter int RFIDX_W = E203_RFIDX_W,
   parameter int XLEN    = E203_XLEN
);
   logic               bpu_req;
   logic [RFIDX_W-1:0] bpu_req_idx;
   logic               bpu_dep;
   logic               bpu_flush;
   logic               bpu_wait;
   logic               bpu_rsp_vld;
   logic [XLEN-1:0]    bpu_rsp_data;

   logic               dbg_req_vld;
   logic               dbg_req_rdy;
   logic [RFIDX_W-1:0] dbg_req_idx;
   logic               dbg_rsp_vld;
   logic               dbg_rsp_rdy;
   logic [XLEN-1:0]    dbg_rsp_data;

   logic               rf_rd_ena;
   logic [RFIDX_W-1:0] rf_rd_idx;
   logic [XLEN-1:0]    rf_rd_data;

   modport slave (
      input  bpu_req, bpu_req_idx, bpu_dep, bpu_flush,
      output bpu_wait, bpu_rsp_vld, bpu_rsp_data,
      input  dbg_req_vld, dbg_req_idx, dbg_rsp_rdy,
      output dbg_req_rdy, dbg_rsp_vld, dbg_rsp_data,
      output rf_rd_ena, rf_rd_idx,
      input  rf_rd_data
   );

   modport master (
      output bpu_req, bpu_req_idx, bpu_dep, bpu_flush,
      input  bpu_wait, bpu_rsp_vld, bpu_rsp_data,
      output dbg_req_vld, dbg_req_idx, dbg_rsp_rdy,
      input  dbg_req_rdy, dbg_rsp_vld, dbg_rsp_data,
      input  rf_rd_ena, rf_rd_idx,
      output rf_rd_data
   );
endinterface

// File: rtl/e203_ifu_rfrd_starve_cnt.sv
// Saturating starvation counter: clear wins over increment, holds otherwise.
module e203_ifu_rfrd_starve_cnt #(
   parameter int MAX = 4,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);

   assign sat = (cnt == W'(MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !sat)
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/e203_ifu_bpu_rfrd_arb.sv
// Arbitrates the shared regfile rs1 read port between the BPU JALR-target
// read and debug abstract-command GPR reads, with debug anti-starvation.
module e203_ifu_bpu_rfrd_arb
   import e203_ifu_bpu_rfrd_arb_pkg::*;
#(
   parameter int RFIDX_W    = E203_RFIDX_W,
   parameter int XLEN       = E203_XLEN,
   parameter int STARVE_MAX = STARVE_MAX_D,
   parameter int CNT_W      = CNT_W_D
) (
   input  logic                          clk,
   input  logic                          rst,
   e203_ifu_bpu_rfrd_arb_if.slave        bus
);

   rfrd_state_e      state, state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             starve_sat;
   logic [XLEN-1:0]  dbg_data_r;
   logic             dbg_cap;
   logic             grant_st;
   logic             bpu_ok, dbg_win, bpu_win;
   logic             bpu_alive;

   // A dropped bpu_req is handled exactly like a flush.
   assign bpu_alive = bus.bpu_req & ~bus.bpu_flush;
   assign grant_st  = (state == IDLE) | (state == DEP_WAIT);
   assign bpu_ok    = bpu_alive & ~bus.bpu_dep;
   assign dbg_win   = grant_st & bus.dbg_req_vld & (~bpu_ok | starve_sat);
   assign bpu_win   = grant_st & bpu_ok & ~dbg_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      bus.rf_rd_ena    = 1'b0;
      bus.rf_rd_idx    = '0;
      bus.dbg_req_rdy  = 1'b0;
      bus.bpu_rsp_vld  = 1'b0;
      bus.bpu_rsp_data = '0;
      bus.dbg_rsp_vld  = 1'b0;
      dbg_cap          = 1'b0;
      unique case (state)
         IDLE, DEP_WAIT: begin
            if (bpu_win) begin
               bus.rf_rd_ena = 1'b1;
               bus.rf_rd_idx = bus.bpu_req_idx;
               state_nxt     = BPU_RD;
            end else if (dbg_win) begin
               bus.rf_rd_ena   = 1'b1;
               bus.rf_rd_idx   = bus.dbg_req_idx;
               bus.dbg_req_rdy = 1'b1;
               state_nxt       = DBG_RD;
            end else if (bpu_alive) begin
               state_nxt = DEP_WAIT;
            end else begin
               state_nxt = IDLE;
            end
         end
         BPU_RD: begin
            bus.bpu_rsp_vld  = bpu_alive;
            bus.bpu_rsp_data = bus.rf_rd_data;
            state_nxt        = IDLE;
         end
         DBG_RD: begin
            dbg_cap   = 1'b1;
            state_nxt = DBG_RSP;
         end
         DBG_RSP: begin
            bus.dbg_rsp_vld = 1'b1;
            if (bus.dbg_rsp_rdy)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // IFU stays stalled until the cycle the response is actually delivered.
   assign bus.bpu_wait = bus.bpu_req & ~((state == BPU_RD) & ~bus.bpu_flush);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dbg_data_r <= '0;
      else if (dbg_cap)
         dbg_data_r <= bus.rf_rd_data;
   end
   assign bus.dbg_rsp_data = dbg_data_r;

   e203_ifu_rfrd_starve_cnt #(
      .MAX (STARVE_MAX),
      .W   (CNT_W)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.dbg_req_rdy),
      .inc (bus.dbg_req_vld & ~bus.dbg_req_rdy),
      .cnt (starve_cnt),
      .sat (starve_sat)
   );

endmodule
